// File: rtl/risc_pkg.sv
// Shared constants for the 8-bit RISC core: datapath widths, opcode
// encodings and execute-stage FSM states.
package risc_pkg;

  localparam int DATA_W = 8;
  localparam int REG_AW = 2;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

endpackage

// File: rtl/exec_stage_if.sv
// Issue (decode -> execute) and write-back (execute -> register file) signals.
interface exec_stage_if #(
  parameter int DATA_W = 8,
  parameter int REG_AW = 2
);

  logic              in_valid;
  logic              in_ready;
  logic [2:0]        opcode;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [REG_AW-1:0] rd;
  logic              flush;
  logic              wb_valid;
  logic [REG_AW-1:0] wb_reg;
  logic [DATA_W-1:0] wb_data;
  logic              zero_flag;
  logic              carry_flag;

  modport master (
    output in_valid, opcode, op_a, op_b, rd, flush,
    input  in_ready, wb_valid, wb_reg, wb_data, zero_flag, carry_flag
  );

  modport slave (
    input  in_valid, opcode, op_a, op_b, rd, flush,
    output in_ready, wb_valid, wb_reg, wb_data, zero_flag, carry_flag
  );

endinterface

// File: rtl/exec_stage_shift_add_mul.sv
// Sequential shift-add multiplier: one partial product per cycle, DATA_W cycles.
// done/product present the final iteration combinationally so the caller can register it.
module shift_add_mul #(
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  output logic                done,
  output logic [2*DATA_W-1:0] product
);
  import risc_pkg::*;

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [2*DATA_W-1:0] mcand_q, mcand_d;
  logic [2*DATA_W-1:0] acc_q, acc_d;
  logic [2*DATA_W-1:0] acc_next;
  logic [DATA_W-1:0]   mplier_q, mplier_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  always_comb begin
    acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    if (abort) begin
      cnt_d = '0;
    end else if (start) begin
      mcand_d  = {{DATA_W{1'b0}}, a};
      mplier_d = b;
      acc_d    = '0;
      cnt_d    = CNT_W'(DATA_W);
    end else if (cnt_q != '0) begin
      // multiplicand shifts left as multiplier shifts right: bit i adds a << i
      acc_d    = acc_next;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - CNT_W'(1);
    end
  end

  assign done    = (cnt_q == CNT_W'(1)) && !abort;
  assign product = acc_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/exec_stage.sv
// Execute stage: single-cycle ALU plus multi-cycle multiply, driving the
// register-file write port one cycle after completion.
module exec_stage #(
  parameter int DATA_W = risc_pkg::DATA_W,
  parameter int REG_AW = risc_pkg::REG_AW
) (
  input  logic         clk,
  input  logic         rst_n,
  exec_stage_if.slave  io
);
  import risc_pkg::*;

  state_e              state_q, state_d;
  logic                in_ready, accept, mul_start, mul_abort, mul_done;
  logic [2*DATA_W-1:0] mul_prod;
  logic [REG_AW-1:0]   mul_rd_q, mul_rd_d;

  logic [DATA_W:0]     sum;
  logic [2*DATA_W-1:0] shl_w, shr_w;
  logic [DATA_W-1:0]   alu_res;
  logic                alu_carry;

  logic                wb_valid_q, wb_valid_d;
  logic [REG_AW-1:0]   wb_reg_q, wb_reg_d;
  logic [DATA_W-1:0]   wb_data_q, wb_data_d;
  logic                zero_q, zero_d;
  logic                carry_q, carry_d;

  shift_add_mul #(.DATA_W(DATA_W)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .abort   (mul_abort),
    .a       (io.op_a),
    .b       (io.op_b),
    .done    (mul_done),
    .product (mul_prod)
  );

  // Shifts run through a double-width window so the last bit shifted out
  // lands at a fixed position (and is 0 for a zero shift).
  always_comb begin
    sum       = {1'b0, io.op_a} + {1'b0, io.op_b};
    shl_w     = {{DATA_W{1'b0}}, io.op_a} << io.op_b[2:0];
    shr_w     = {io.op_a, {DATA_W{1'b0}}} >> io.op_b[2:0];
    alu_res   = '0;
    alu_carry = 1'b0;
    case (io.opcode)
      OP_ADD: begin alu_res = sum[DATA_W-1:0]; alu_carry = sum[DATA_W]; end
      OP_SUB: begin alu_res = io.op_a - io.op_b; alu_carry = (io.op_a < io.op_b); end
      OP_AND: alu_res = io.op_a & io.op_b;
      OP_OR:  alu_res = io.op_a | io.op_b;
      OP_XOR: alu_res = io.op_a ^ io.op_b;
      OP_SHL: begin alu_res = shl_w[DATA_W-1:0]; alu_carry = shl_w[DATA_W]; end
      OP_SHR: begin alu_res = shr_w[2*DATA_W-1:DATA_W]; alu_carry = shr_w[DATA_W-1]; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (mul_start) state_d = ST_MUL;
      ST_MUL:  if (io.flush || mul_done) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == ST_IDLE) && !io.flush;
    accept    = io.in_valid && in_ready;
    mul_start = accept && (io.opcode == OP_MUL);
    mul_abort = io.flush && (state_q == ST_MUL);
  end

  // Flush wins over a multiply finishing on the same edge.
  always_comb begin
    mul_rd_d   = mul_start ? io.rd : mul_rd_q;
    wb_valid_d = 1'b0;
    wb_reg_d   = wb_reg_q;
    wb_data_d  = wb_data_q;
    zero_d     = zero_q;
    carry_d    = carry_q;
    if (accept && (io.opcode != OP_MUL)) begin
      wb_valid_d = 1'b1;
      wb_reg_d   = io.rd;
      wb_data_d  = alu_res;
      zero_d     = (alu_res == '0);
      carry_d    = alu_carry;
    end else if ((state_q == ST_MUL) && mul_done && !io.flush) begin
      wb_valid_d = 1'b1;
      wb_reg_d   = mul_rd_q;
      wb_data_d  = mul_prod[DATA_W-1:0];
      zero_d     = (mul_prod[DATA_W-1:0] == '0);
      carry_d    = |mul_prod[2*DATA_W-1:DATA_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_rd_q   <= '0;
      wb_valid_q <= 1'b0;
      wb_reg_q   <= '0;
      wb_data_q  <= '0;
      zero_q     <= 1'b0;
      carry_q    <= 1'b0;
    end else begin
      mul_rd_q   <= mul_rd_d;
      wb_valid_q <= wb_valid_d;
      wb_reg_q   <= wb_reg_d;
      wb_data_q  <= wb_data_d;
      zero_q     <= zero_d;
      carry_q    <= carry_d;
    end
  end

  assign io.in_ready   = in_ready;
  assign io.wb_valid   = wb_valid_q;
  assign io.wb_reg     = wb_reg_q;
  assign io.wb_data    = wb_data_q;
  assign io.zero_flag  = zero_q;
  assign io.carry_flag = carry_q;

endmodule

// File: tb/tb_exec_stage.sv
// Randomized + directed bench for exec_stage against an arithmetic reference model.
module tb_exec_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;

  int   bop[8], ba[8], bb[8], brd[8];

  exec_stage_if #(.DATA_W(8), .REG_AW(2)) io();

  exec_stage #(.DATA_W(8), .REG_AW(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (io)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // {carry, data} computed from the operation's arithmetic definition
  function automatic logic [8:0] ref_op(input int op, input int a, input int b);
    int r, c, amt;
    r = 0; c = 0; amt = b % 8;
    case (op)
      0: begin r = a + b; c = (r > 255); end
      1: begin r = a - b; c = (a < b); end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: begin r = a << amt; c = (amt != 0) ? ((a >> (8 - amt)) & 1) : 0; end
      6: begin r = a >> amt; c = (amt != 0) ? ((a >> (amt - 1)) & 1) : 0; end
      default: begin r = a * b; c = (r > 255); end
    endcase
    return {c[0], r[7:0]};
  endfunction

  task automatic drive(input int op, input int a, input int b, input int rd);
    io.in_valid = 1'b1;
    io.opcode   = op[2:0];
    io.op_a     = a[7:0];
    io.op_b     = b[7:0];
    io.rd       = rd[1:0];
  endtask

  task automatic wait_ready();
    int w;
    w = 0;
    while (io.in_ready !== 1'b1 && w < 20) begin @(negedge clk); w++; end
    chk("issue_rdy", io.in_ready, 1);
  endtask

  task automatic check_wb(input string tag, input int rd, input logic [8:0] e);
    chk({tag, "_wbv"},   io.wb_valid, 1);
    chk({tag, "_reg"},   io.wb_reg, rd[1:0]);
    chk({tag, "_data"},  io.wb_data, e[7:0]);
    chk({tag, "_zero"},  io.zero_flag, (e[7:0] == 8'd0));
    chk({tag, "_carry"}, io.carry_flag, e[8]);
  endtask

  // Single issue with full latency check; called and returns just after a negedge.
  task automatic do_op(input int op, input int a, input int b, input int rd);
    logic [8:0] e;
    wait_ready();
    e = ref_op(op, a, b);
    drive(op, a, b, rd);
    @(posedge clk); #1 io.in_valid = 1'b0;
    if (op == 7) begin
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        chk("mul_busy_rdy", io.in_ready, 0);
        chk("mul_busy_wbv", io.wb_valid, 0);
      end
    end
    @(negedge clk);
    check_wb(op == 7 ? "mul" : "alu", rd, e);
    chk("wb_cycle_rdy", io.in_ready, 1);
    if (op != 7) begin
      @(negedge clk);
      chk("wb_pulse", io.wb_valid, 0);
      chk("wb_hold", io.wb_data, e[7:0]);
    end
  endtask

  // Back-to-back non-MUL issues from the b* tables, one per cycle.
  task automatic burst(input int n);
    wait_ready();
    drive(bop[0], ba[0], bb[0], brd[0]);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (i + 1 < n) drive(bop[i+1], ba[i+1], bb[i+1], brd[i+1]);
      else io.in_valid = 1'b0;
      @(negedge clk);
      check_wb("burst", brd[i], ref_op(bop[i], ba[i], bb[i]));
      if (i + 1 < n) chk("burst_rdy", io.in_ready, 1);
    end
  endtask

  initial begin
    int w;
    io.in_valid = 1'b0; io.opcode = 3'd0; io.op_a = 8'd0; io.op_b = 8'd0;
    io.rd = 2'd0; io.flush = 1'b0;

    #3;
    chk("rst_wbv", io.wb_valid, 0);
    chk("rst_reg", io.wb_reg, 0);
    chk("rst_data", io.wb_data, 0);
    chk("rst_zero", io.zero_flag, 0);
    chk("rst_carry", io.carry_flag, 0);
    chk("rst_rdy", io.in_ready, 1);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // directed cases
    do_op(0, 10, 20, 3);
    do_op(1, 20, 20, 1);
    do_op(1, 5, 10, 0);
    do_op(0, 8'hFF, 1, 2);
    do_op(5, 8'h81, 1, 1);
    do_op(6, 8'h81, 1, 2);
    do_op(5, 8'h81, 0, 3);
    do_op(7, 20, 30, 3);
    do_op(7, 5, 10, 2);
    do_op(7, 255, 255, 1);

    // flush after four multiply iterations, with a competing issue
    wait_ready();
    drive(7, 20, 30, 1);
    @(posedge clk); #1 io.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 io.flush = 1'b1;
    drive(0, 1, 1, 2);
    #1 chk("flush_rdy", io.in_ready, 0);
    @(posedge clk); #1 io.flush = 1'b0; io.in_valid = 1'b0;
    @(negedge clk);
    chk("flush_rdy_after", io.in_ready, 1);
    w = 0;
    repeat (10) begin if (io.wb_valid) w++; @(negedge clk); end
    chk("flush_no_wb", w, 0);
    do_op(0, 5, 5, 2);

    // four back-to-back: ADD, XOR, OR, AND
    bop = '{0, 4, 3, 2, 0, 0, 0, 0};
    ba  = '{10, 8'hF0, 8'h0C, 8'h3C, 0, 0, 0, 0};
    bb  = '{20, 8'hFF, 8'h30, 8'h0F, 0, 0, 0, 0};
    brd = '{0, 1, 2, 3, 0, 0, 0, 0};
    burst(4);

    // flush does not cancel a write-back already presented, but blocks the issue
    @(negedge clk);
    drive(0, 7, 8, 1);
    @(posedge clk); #1 io.flush = 1'b1; drive(4, 8'hAA, 8'h55, 3);
    @(negedge clk);
    chk("flush_wb_kept", io.wb_valid, 1);
    chk("flush_wb_data", io.wb_data, 15);
    chk("flush_blk_rdy", io.in_ready, 0);
    @(posedge clk); #1 io.flush = 1'b0; io.in_valid = 1'b0;
    @(negedge clk);
    chk("flush_blk_wbv", io.wb_valid, 0);
    chk("flush_blk_data", io.wb_data, 15);

    // randomized mix of single issues and bursts
    for (int t = 0; t < 60; t++) begin
      if ($urandom_range(0, 4) == 0) begin
        for (int i = 0; i < 8; i++) begin
          bop[i] = $urandom_range(0, 6); ba[i] = $urandom_range(0, 255);
          bb[i] = $urandom_range(0, 255); brd[i] = $urandom_range(0, 3);
        end
        burst($urandom_range(2, 8));
        @(negedge clk);
      end else begin
        do_op($urandom_range(0, 7), $urandom_range(0, 255), $urandom_range(0, 255),
              $urandom_range(0, 3));
      end
    end

    // async reset in the middle of a multiply
    do_op(0, 1, 2, 2);
    wait_ready();
    drive(7, 20, 30, 3);
    @(posedge clk); #1 io.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_wbv", io.wb_valid, 0);
    chk("arst_reg", io.wb_reg, 0);
    chk("arst_data", io.wb_data, 0);
    chk("arst_zero", io.zero_flag, 0);
    chk("arst_carry", io.carry_flag, 0);
    chk("arst_rdy", io.in_ready, 1);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    w = 0;
    repeat (12) begin @(negedge clk); if (io.wb_valid) w++; end
    chk("arst_no_wb", w, 0);
    do_op(0, 5, 5, 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/exec_stage.md
# exec_stage

Execute stage of the 8-bit RISC core, sitting directly upstream of the 4-entry register file. It takes the two operands read from the register file plus a decoded opcode and destination index, computes the result, and drives the register-file write port (`reg_write`, `write_reg`, `write_data`) one cycle later. Multiply is a multi-cycle shift-add operation that stalls the issue handshake.

## Interface

Parameters:
- `DATA_W`, 8, operand/result width; also the multiply iteration count.
- `REG_AW`, 2, register index width.

Ports:
- `clk`  in  1  system clock, all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  issue request from decode.
- `in_ready`  out  1  stage can accept; transfer on `in_valid && in_ready` at a rising edge.
- `opcode`  in  3  ADD=0, SUB=1, AND=2, OR=3, XOR=4, SHL=5, SHR=6, MUL=7.
- `op_a`, `op_b`  in  DATA_W  operands (register file `read_data1`/`read_data2`).
- `rd`  in  REG_AW  destination register index.
- `flush`  in  1  synchronous abort of any in-flight operation.
- `wb_valid`  out  1  one-cycle write strobe; connects to register-file `reg_write`.
- `wb_reg`  out  REG_AW  destination index; connects to `write_reg`.
- `wb_data`  out  DATA_W  result; connects to `write_data`.
- `zero_flag`  out  1  `wb_data == 0` for the last completed op.
- `carry_flag`  out  1  carry/borrow/overflow for the last completed op.

## Operation

- States: IDLE, MUL. Reset enters IDLE.
- `in_ready = (state == IDLE) && !flush`; combinational.
- Non-MUL accept in IDLE: result, `rd`, and flags registered at the accept edge; state stays IDLE.
- ADD: 9-bit sum; `carry` = bit 8. SUB: `op_a - op_b` mod 2^DATA_W; `carry` = borrow (`op_a < op_b`).
- AND/OR/XOR: `carry` = 0.
- SHL/SHR: shift amount `op_b[2:0]`, zero fill. `carry` = last bit shifted out; 0 when the amount is 0.
- MUL accept: latch operands and `rd`, clear the 2·DATA_W accumulator, load the counter with DATA_W, go to MUL.
- MUL iteration: add `op_a << i` when multiplier bit i is set; decrement the counter.
- After the last iteration: register `wb_data` = product[DATA_W-1:0] and `carry` = (product[2·DATA_W-1:DATA_W] != 0), then return to IDLE.
- `wb_valid` is high for exactly one cycle per completed op. There is no downstream backpressure.
- `wb_reg`, `wb_data` and the flags hold their values until the next completion.
- `flush`:
  - Abandons a MUL with no `wb_valid` and returns to IDLE; `in_ready` goes high in the following cycle.
  - `flush` asserted with `in_valid` blocks the accept.
  - `flush` does not suppress a `wb_valid` already being presented.
- Async reset mid-operation discards all state immediately.

## Timing

- Reset values: `wb_valid`=0, `wb_reg`=0, `wb_data`=0, `zero_flag`=0, `carry_flag`=0, state IDLE. `in_ready`=1 while in reset unless `flush` is high.
- Non-MUL latency 1: accept at edge E0, `wb_valid` high during the cycle after E0.
- Back-to-back non-MUL issue every cycle yields one `wb_valid` per cycle.
- MUL: accept at E0, iterations at E1..E_DATA_W, `wb_valid` high in the cycle after E_DATA_W (latency DATA_W+1).
- During a MUL, `in_ready` is low for the DATA_W cycles after E0. It rises in the same cycle `wb_valid` is high, so a new issue can overlap that write-back.
- Read-after-write hazards are resolved by the register file write on the `wb_valid` edge. This stage performs no forwarding.

## Structure

- Shared package `risc_pkg`: opcode localparams, `DATA_W`, `REG_AW`, and state encodings.
- Sub-module `shift_add_mul`: a sequential multiplier with its own `start`/`done`, counter and accumulator.
- `exec_stage` holds the combinational ALU, the FSM, and the write-back registers.

## Test plan

- ADD `op_a`=10, `op_b`=20, `rd`=3 -> next cycle `wb_valid`=1, `wb_reg`=3, `wb_data`=30, zero=0, carry=0. Then SUB 20−20 -> `wb_data`=0, zero=1.
- SUB 5−10 -> `wb_data`=0xFB, carry=1. ADD 0xFF+0x01 -> `wb_data`=0x00, zero=1, carry=1. SHL 0x81 by 1 -> `wb_data`=0x02, carry=1.
- MUL 20×30 -> `in_ready` low for 8 cycles; `wb_valid` 9 cycles after accept with `wb_data`=0x58, carry=1. MUL 5×10 -> `wb_data`=50, carry=0.
- MUL 20×30 with `flush` after 4 iterations -> no `wb_valid`; `in_ready`=1 the next cycle; a following ADD 5+5 writes 10.
- Four back-to-back issues (ADD, XOR, OR, AND) -> four consecutive `wb_valid` cycles with correct `wb_reg`/`wb_data` each.
- Deassert `rst_n` asynchronously mid-MUL -> all outputs immediately 0, no `wb_valid` after release, first post-reset ADD completes normally.
